// File: rtl/ntt_pkg.sv
// Shared constants and buffer-state type for the 16-point NTT front end.
// No logic; sizes and the default modulus live here so every stage agrees.
package ntt_pkg;

    localparam int unsigned NTT_N     = 16;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned Q_DEFAULT = 3329;
    localparam int unsigned IDX_W     = $clog2(NTT_N);
    localparam int unsigned FRAME_W   = NTT_N * DATA_W;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_e;

endpackage

// File: rtl/ntt_frame_buf.sv
// One ping-pong frame buffer: 16x16 coefficient storage plus its EMPTY/FILLING/FULL state.
// Latency: a write lands at the next edge; full_o rises the edge after the last write.
// Backpressure: none locally; the parent only writes when not full and only releases when full.
module ntt_frame_buf
    import ntt_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic               wr_last_i,
    input  logic               rd_done_i,
    output logic               full_o,
    output logic [FRAME_W-1:0] data_o
);

    logic [NTT_N-1:0][DATA_W-1:0] mem_q;
    buf_state_e                   state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: begin
                if (wr_en_i) begin
                    state_d = wr_last_i ? BUF_FULL : BUF_FILLING;
                end
            end
            BUF_FILLING: begin
                if (wr_en_i && wr_last_i) begin
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (rd_done_i) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        full_o = (state_q == BUF_FULL);
        data_o = mem_q;
    end

endmodule

// File: rtl/ntt_frame_loader.sv
// Serial-to-parallel loader: collects 16 coefficients into ping-pong buffers for the NTT stage.
// Latency: frame_valid one cycle after index 15 is accepted; full-rate streaming, no frame-boundary bubble.
// Backpressure: in_ready drops only while both buffers are FULL. Optional mod-Q input reduction: LOADER_MODRED_EN.
module ntt_frame_loader
    import ntt_pkg::*;
#(
    parameter int unsigned Q = Q_DEFAULT,
    parameter int unsigned N = NTT_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_sof,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [N*DATA_W-1:0]   frame_data,
    output logic                  sof_err
);

    // The butterfly network is hard-wired for 16 lanes and Q must fit one coefficient.
    if (N != NTT_N || Q == 0 || Q >= (1 << DATA_W)) begin : g_bad_cfg
        $error("ntt_frame_loader: unsupported N or Q");
    end

    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic               sof_err_q, sof_err_d;
    logic [IDX_W-1:0]   eff_idx;
    logic [DATA_W-1:0]  wr_data;
    logic               accept, consume, wr_last;
    logic [1:0]         wr_en, rd_done, buf_full;
    logic [FRAME_W-1:0] buf_data [2];

`ifdef LOADER_MODRED_EN
    localparam logic [DATA_W-1:0] Q_W = DATA_W'(Q);
    assign wr_data = (in_data >= Q_W) ? (in_data - Q_W) : in_data;
`else
    assign wr_data = in_data;
`endif

    assign in_ready    = ~buf_full[wr_ptr_q];
    assign frame_valid = buf_full[rd_ptr_q];
    assign frame_data  = buf_data[rd_ptr_q];
    assign sof_err     = sof_err_q;

    assign accept  = in_valid & in_ready;
    assign consume = frame_valid & frame_ready;
    // A start-of-frame always lands at lane 0, dropping whatever partial frame was in progress.
    assign eff_idx = in_sof ? '0 : wr_idx_q;
    assign wr_last = (eff_idx == IDX_W'(NTT_N - 1));

    assign wr_en   = {accept & wr_ptr_q, accept & ~wr_ptr_q};
    assign rd_done = {consume & rd_ptr_q, consume & ~rd_ptr_q};

    ntt_frame_buf u_buf0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en[0]),
        .wr_idx_i  (eff_idx),
        .wr_data_i (wr_data),
        .wr_last_i (wr_last),
        .rd_done_i (rd_done[0]),
        .full_o    (buf_full[0]),
        .data_o    (buf_data[0])
    );

    ntt_frame_buf u_buf1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en[1]),
        .wr_idx_i  (eff_idx),
        .wr_data_i (wr_data),
        .wr_last_i (wr_last),
        .rd_done_i (rd_done[1]),
        .full_o    (buf_full[1]),
        .data_o    (buf_data[1])
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wr_idx_d  = wr_idx_q;
        sof_err_d = sof_err_q;
        if (accept) begin
            if (in_sof && (wr_idx_q != '0)) begin
                sof_err_d = 1'b1;
            end
            if (wr_last) begin
                wr_idx_d = '0;
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_idx_d = eff_idx + 1'b1;
            end
        end
        if (consume) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            wr_idx_q  <= '0;
            sof_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_idx_q  <= wr_idx_d;
            sof_err_q <= sof_err_d;
        end
    end

endmodule

// File: tb/tb_ntt_frame_loader.sv
// Directed and randomized bench for ntt_frame_loader against a queue-based frame model.
module tb_ntt_frame_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         in_sof;
    logic         frame_valid;
    logic         frame_ready;
    logic [255:0] frame_data;
    logic         sof_err;

    always #5 clk = ~clk;

    ntt_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .sof_err     (sof_err)
    );

    int passes = 0;
    int total  = 0;

    // Reference model: partial frame being collected, and completed frames awaiting consumption.
    logic [15:0]  cur [$];
    logic [255:0] full_q [$];
    bit           sof_err_m;
    int           cyc;
    int           acc_cnt;
    int           rdy_low_cnt;
    int           vld_cyc [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] red(input logic [15:0] v);
`ifdef LOADER_MODRED_EN
        return (v >= 16'd3329) ? (v - 16'd3329) : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [255:0] pack_cur();
        logic [255:0] r = '0;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = cur[i];
        return r;
    endfunction

    // One clock: drive at negedge, compare against the model, then advance the model at the edge.
    task automatic step(input bit v, input logic [15:0] d, input bit s, input bit fr);
        bit exp_rdy, exp_vld, acc, cons;
        in_valid    = v;
        in_data     = d;
        in_sof      = s;
        frame_ready = fr;
        #1;
        exp_rdy = (full_q.size() < 2);
        exp_vld = (full_q.size() > 0);
        chk("in_ready", in_ready, exp_rdy);
        chk("frame_valid", frame_valid, exp_vld);
        chk("sof_err", sof_err, sof_err_m);
        if (exp_vld) chk("frame_data", frame_data, full_q[0]);
        if (v && in_ready) acc_cnt++;
        if (!in_ready) rdy_low_cnt++;
        if (frame_valid) vld_cyc.push_back(cyc);
        acc  = v && exp_rdy;
        cons = exp_vld && fr;
        @(posedge clk);
        if (cons) void'(full_q.pop_front());
        if (acc) begin
            if (s && cur.size() != 0) begin
                cur.delete();
                sof_err_m = 1'b1;
            end
            cur.push_back(red(d));
            if (cur.size() == 16) begin
                full_q.push_back(pack_cur());
                cur.delete();
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        in_data     = '0;
        frame_ready = 1'b0;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_frame_valid"}, frame_valid, 1'b0);
        chk({tag, "_frame_data"}, frame_data, '0);
        chk({tag, "_sof_err"}, sof_err, 1'b0);
        cur.delete();
        full_q.delete();
        sof_err_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        acc_cnt     = 0;
        rdy_low_cnt = 0;
        vld_cyc.delete();
    endtask

    initial begin
        logic [255:0] exp_f;
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; frame_ready = 1'b0;
        cyc = 0;
        @(negedge clk);
        do_reset("por");

        // Single frame, value i*3, immediate consumption.
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i * 3), 1'b0, 1'b1);
        exp_f = '0;
        for (int i = 0; i < 16; i++) exp_f[16*i +: 16] = 16'(i * 3);
        chk("single_valid", frame_valid, 1'b1);
        chk("single_lanes", frame_data, exp_f);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("single_pulse_end", frame_valid, 1'b0);

        // Back-pressure: 40 back-to-back offers, nothing consumed.
        do_reset("rst_bp");
        for (int i = 0; i < 40; i++) step(1'b1, 16'(500 + i), 1'b0, 1'b0);
        chk("bp_accepted", acc_cnt, 32);
        chk("bp_ready_low", in_ready, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("bp_ready_after_consume", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

        // Streaming: 4 frames at full rate.
        do_reset("rst_stream");
        for (int i = 0; i < 64; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("stream_ready_low_cycles", rdy_low_cnt, 0);
        chk("stream_pulses", vld_cyc.size(), 4);
        for (int i = 1; i < vld_cyc.size(); i++)
            chk("stream_spacing", vld_cyc[i] - vld_cyc[i-1], 16);

        // Resync: start-of-frame arriving at index 7.
        do_reset("rst_resync");
        for (int i = 0; i < 7; i++) step(1'b1, 16'(i + 1), 1'b0, 1'b1);
        step(1'b1, 16'h0abc, 1'b1, 1'b1);
        chk("resync_sof_err", sof_err, 1'b1);
        for (int i = 1; i < 16; i++) step(1'b1, 16'(40 + i), 1'b0, 1'b0);
        chk("resync_valid", frame_valid, 1'b1);
        chk("resync_lane0", frame_data[15:0], 16'h0abc);
        chk("resync_lane15", frame_data[255:240], 16'd55);
        step(1'b0, 16'h0, 1'b0, 1'b1);

        // Modular reduction boundary values.
        do_reset("rst_modred");
        step(1'b1, 16'd3328, 1'b0, 1'b1);
        step(1'b1, 16'd3329, 1'b0, 1'b1);
        step(1'b1, 16'd4000, 1'b0, 1'b1);
        for (int i = 3; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
`ifdef LOADER_MODRED_EN
        chk("modred_lanes", frame_data[47:0], {16'd671, 16'd0, 16'd3328});
`else
        chk("modred_lanes", frame_data[47:0], {16'd4000, 16'd3329, 16'd3328});
`endif
        step(1'b0, 16'h0, 1'b0, 1'b1);

        // Reset after 9 coefficients, then a fresh frame.
        do_reset("rst_pre_mid");
        for (int i = 0; i < 9; i++) step(1'b1, 16'(900 + i), 1'b0, 1'b1);
        do_reset("midrst");
        for (int i = 0; i < 16; i++) step(1'b1, 16'(100 + i), 1'b0, 1'b0);
        exp_f = '0;
        for (int i = 0; i < 16; i++) exp_f[16*i +: 16] = 16'(100 + i);
        chk("midrst_frame", frame_data, exp_f);
        step(1'b0, 16'h0, 1'b0, 1'b1);

        // Randomized traffic with occasional start-of-frame markers.
        do_reset("rst_rand");
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) != 0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("rand_drained", frame_valid, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
